// File: rtl/data_memory_unit.sv
// Memory stage after the load-store queue: one request in flight, fixed-latency
// access to a little-endian byte-addressable RAM, completion returned via valid/ready.
module data_memory_unit #(
   parameter int DEPTH   = 256,
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_pc,
   input  logic [31:0] req_addr,
   input  logic        req_is_store,
   input  logic        req_size,
   input  logic [31:0] req_store_data,
   input  logic        req_fwd,
   input  logic [31:0] req_fwd_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_pc,
   output logic [31:0] resp_data,
   output logic        resp_is_store,
   output logic        resp_error
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_pc;
   logic [31:0]   r_addr;
   logic          r_is_store;
   logic          r_size;
   logic [31:0]   r_wdata;
   logic [31:0]   r_ram [DEPTH];

   logic          r_req_ready;
   logic          r_resp_valid;
   logic [31:0]   r_resp_pc;
   logic [31:0]   r_resp_data;
   logic          r_resp_is_store;
   logic          r_resp_error;

   logic [AW-1:0] w_idx;
   logic [1:0]    w_lane;
   logic [31:0]   w_word;
   logic          w_misaligned;

   // Upper address bits are dropped so accesses wrap modulo DEPTH words.
   assign w_idx        = r_addr[AW+1:2];
   assign w_lane       = r_addr[1:0];
   assign w_word       = r_ram[w_idx];
   assign w_misaligned = !r_size && (w_lane != 2'd0);

   function automatic logic [31:0] sext_byte(input logic [31:0] word, input logic [1:0] lane);
      logic signed [7:0]  b;
      logic signed [31:0] ext;
      b   = word[lane*8 +: 8];
      ext = b;
      return ext;
   endfunction

   function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [7:0] b);
      logic [31:0] res;
      res = word;
      res[lane*8 +: 8] = b;
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_req_ready     <= 1'b0;
         r_resp_valid    <= 1'b0;
         r_resp_pc       <= '0;
         r_resp_data     <= '0;
         r_resp_is_store <= 1'b0;
         r_resp_error    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_ram[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_req_ready <= 1'b1;
               if (req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_pc        <= req_pc;
                  r_addr      <= req_addr;
                  r_is_store  <= req_is_store;
                  r_size      <= req_size;
                  r_wdata     <= req_store_data;
                  // A forwarded load completes without touching the RAM.
                  if (req_fwd && !req_is_store) begin
                     r_state         <= S_RESP;
                     r_resp_valid    <= 1'b1;
                     r_resp_pc       <= req_pc;
                     r_resp_data     <= req_fwd_data;
                     r_resp_is_store <= 1'b0;
                     r_resp_error    <= 1'b0;
                  end else begin
                     r_state <= S_ACCESS;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            S_ACCESS: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_state         <= S_RESP;
                  r_resp_valid    <= 1'b1;
                  r_resp_pc       <= r_pc;
                  r_resp_is_store <= r_is_store;
                  r_resp_error    <= w_misaligned;
                  if (w_misaligned || r_is_store) begin
                     r_resp_data <= '0;
                  end else begin
                     r_resp_data <= r_size ? sext_byte(w_word, w_lane) : w_word;
                  end
                  if (r_is_store && !w_misaligned) begin
                     r_ram[w_idx] <= r_size ? merge_byte(w_word, w_lane, r_wdata[7:0]) : r_wdata;
                  end
               end
            end
            S_RESP: begin
               if (r_resp_valid && resp_ready) begin
                  r_state      <= S_IDLE;
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready     = r_req_ready;
   assign resp_valid    = r_resp_valid;
   assign resp_pc       = r_resp_pc;
   assign resp_data     = r_resp_data;
   assign resp_is_store = r_resp_is_store;
   assign resp_error    = r_resp_error;
endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: vector table on a MEM_LAT=2 instance,
// plus back-pressure and mid-access reset sequences (reset one on a MEM_LAT=3 instance).
module tb_data_memory_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_valid3;
   logic [31:0] req_pc, req_addr, req_store_data, req_fwd_data;
   logic        req_is_store, req_size, req_fwd;
   logic        resp_ready;

   logic        rdy2, vld2, st2, err2;
   logic [31:0] pc2, dat2;
   logic        rdy3, vld3, st3, err3;
   logic [31:0] pc3, dat3;

   logic        sel3;
   logic        m_rdy, m_vld, m_st, m_err;
   logic [31:0] m_pc, m_dat;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   data_memory_unit #(.DEPTH(256), .MEM_LAT(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2),
      .req_pc(req_pc), .req_addr(req_addr), .req_is_store(req_is_store),
      .req_size(req_size), .req_store_data(req_store_data), .req_fwd(req_fwd),
      .req_fwd_data(req_fwd_data), .resp_valid(vld2), .resp_ready(resp_ready),
      .resp_pc(pc2), .resp_data(dat2), .resp_is_store(st2), .resp_error(err2));

   data_memory_unit #(.DEPTH(256), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(rdy3),
      .req_pc(req_pc), .req_addr(req_addr), .req_is_store(req_is_store),
      .req_size(req_size), .req_store_data(req_store_data), .req_fwd(req_fwd),
      .req_fwd_data(req_fwd_data), .resp_valid(vld3), .resp_ready(resp_ready),
      .resp_pc(pc3), .resp_data(dat3), .resp_is_store(st3), .resp_error(err3));

   always_comb begin
      m_rdy = sel3 ? rdy3 : rdy2;
      m_vld = sel3 ? vld3 : vld2;
      m_st  = sel3 ? st3  : st2;
      m_err = sel3 ? err3 : err2;
      m_pc  = sel3 ? pc3  : pc2;
      m_dat = sel3 ? dat3 : dat2;
   end

   typedef struct {
      logic        is_store;
      logic        size;
      logic        fwd;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] fdata;
      logic [31:0] exp_data;
      logic        exp_store;
      logic        exp_err;
      int          exp_wait;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic st, logic sz, logic fw, logic [31:0] pc, logic [31:0] a,
                               logic [31:0] wd, logic [31:0] fd, logic [31:0] ed,
                               logic err, int w);
      vec_t v;
      v.is_store = st; v.size = sz; v.fwd = fw; v.pc = pc; v.addr = a;
      v.wdata = wd; v.fdata = fd; v.exp_data = ed; v.exp_store = st;
      v.exp_err = err; v.exp_wait = w;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      req_pc = v.pc; req_addr = v.addr; req_is_store = v.is_store; req_size = v.size;
      req_store_data = v.wdata; req_fwd = v.fwd; req_fwd_data = v.fdata;
   endtask

   // Called at a negedge with the selected unit idle; resp_ready assumed 1.
   task automatic run_req(input vec_t v, input string tag);
      int waited;
      chk({tag, " req_ready before"}, 32'(m_rdy), 32'd1);
      drive(v);
      if (sel3) req_valid3 = 1'b1; else req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_valid3 = 1'b0;
      waited = 0;
      @(negedge clk);
      while (!m_vld && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk({tag, " resp_valid"}, 32'(m_vld), 32'd1);
      chk({tag, " latency"}, 32'(waited), 32'(v.exp_wait));
      chk({tag, " resp_pc"}, m_pc, v.pc);
      chk({tag, " resp_data"}, m_dat, v.exp_data);
      chk({tag, " resp_is_store"}, 32'(m_st), 32'(v.exp_store));
      chk({tag, " resp_error"}, 32'(m_err), 32'(v.exp_err));
      @(negedge clk);
      chk({tag, " resp_valid after handshake"}, 32'(m_vld), 32'd0);
      chk({tag, " req_ready after handshake"}, 32'(m_rdy), 32'd1);
   endtask

   initial begin
      vec_t v;
      vecs[0]  = mk(1, 0, 0, 32'h04, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 2);
      vecs[1]  = mk(0, 0, 0, 32'h08, 32'h10, 0, 0, 32'hDEADBEEF, 0, 2);
      vecs[2]  = mk(1, 0, 0, 32'h10, 32'h20, 32'h11223344, 0, 32'h0, 0, 2);
      vecs[3]  = mk(1, 1, 0, 32'h14, 32'h22, 32'h000000AA, 0, 32'h0, 0, 2);
      vecs[4]  = mk(0, 0, 0, 32'h18, 32'h20, 0, 0, 32'h11AA3344, 0, 2);
      vecs[5]  = mk(0, 1, 0, 32'h1C, 32'h22, 0, 0, 32'hFFFFFFAA, 0, 2);
      vecs[6]  = mk(0, 1, 0, 32'h20, 32'h23, 0, 0, 32'h00000011, 0, 2);
      vecs[7]  = mk(0, 0, 1, 32'h0C, 32'h20, 0, 32'h55, 32'h00000055, 0, 0);
      vecs[8]  = mk(0, 0, 0, 32'h24, 32'h20, 0, 0, 32'h11AA3344, 0, 2);
      vecs[9]  = mk(1, 0, 0, 32'h28, 32'h31, 32'h12345678, 0, 32'h0, 1, 2);
      vecs[10] = mk(0, 0, 0, 32'h2C, 32'h30, 0, 0, 32'h00000000, 0, 2);
      vecs[11] = mk(1, 0, 1, 32'h30, 32'h50, 32'hCAFEF00D, 32'h99, 32'h0, 0, 2);
      vecs[12] = mk(0, 0, 0, 32'h34, 32'h50, 0, 0, 32'hCAFEF00D, 0, 2);
      vecs[13] = mk(0, 0, 0, 32'h38, 32'h10000050, 0, 0, 32'hCAFEF00D, 0, 2);
      vecs[14] = mk(0, 0, 0, 32'h3C, 32'h52, 0, 0, 32'h0, 1, 2);
      vecs[15] = mk(0, 1, 0, 32'h40, 32'h13, 0, 0, 32'hFFFFFFDE, 0, 2);

      sel3 = 1'b0; rst = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; resp_ready = 1'b1;
      drive(vecs[0]);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset req_ready", 32'(rdy2), 32'd0);
      chk("reset resp_valid", 32'(vld2), 32'd0);
      chk("reset resp_pc", pc2, 32'd0);
      chk("reset resp_data", dat2, 32'd0);
      chk("reset resp_is_store", 32'(st2), 32'd0);
      chk("reset resp_error", 32'(err2), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("req_ready first cycle out of reset", 32'(rdy2), 32'd0);
      @(negedge clk);
      chk("req_ready after reset", 32'(rdy2), 32'd1);

      for (int i = 0; i < 16; i++) run_req(vecs[i], $sformatf("vec%0d", i));

      // Back-pressure: completion held while resp_ready is low.
      resp_ready = 1'b0;
      v = mk(0, 0, 0, 32'h44, 32'h10, 0, 0, 32'hDEADBEEF, 0, 2);
      drive(v);
      req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp%0d resp_valid", k), 32'(vld2), 32'd1);
         chk($sformatf("bp%0d resp_pc", k), pc2, 32'h44);
         chk($sformatf("bp%0d resp_data", k), dat2, 32'hDEADBEEF);
         chk($sformatf("bp%0d req_ready", k), 32'(rdy2), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp resp_valid after handshake", 32'(vld2), 32'd0);
      chk("bp req_ready after handshake", 32'(rdy2), 32'd1);
      @(negedge clk);
      chk("bp single handshake", 32'(vld2), 32'd0);

      // Reset while a MEM_LAT=3 store is still in ACCESS.
      sel3 = 1'b1;
      chk("m3 req_ready idle", 32'(rdy3), 32'd1);
      v = mk(1, 0, 0, 32'h48, 32'h40, 32'h77, 0, 32'h0, 0, 3);
      drive(v);
      req_valid3 = 1'b1;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("m3 rst req_ready", 32'(rdy3), 32'd0);
      chk("m3 rst resp_valid", 32'(vld3), 32'd0);
      chk("m3 rst resp_pc", pc3, 32'd0);
      chk("m3 rst resp_data", dat3, 32'd0);
      chk("m3 rst resp_is_store", 32'(st3), 32'd0);
      chk("m3 rst resp_error", 32'(err3), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("m3 no resp %0d", k), 32'(vld3), 32'd0);
      end
      chk("m3 req_ready after reset", 32'(rdy3), 32'd1);
      v = mk(0, 0, 0, 32'h4C, 32'h40, 0, 0, 32'h0, 0, 3);
      run_req(v, "m3 load after abort");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
